// File: rtl/rr_counter_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin counter arbiter.
// The master side drives requests and done; the slave side (the arbiter) drives the grant.
interface rr_counter_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [W-1:0]     gnt_id;
    logic             timeout;

    modport master (output req, done, input gnt, gnt_valid, gnt_id, timeout);
    modport slave  (input req, done, output gnt, gnt_valid, gnt_id, timeout);
endinterface

// File: rtl/rr_counter_arbiter.sv
// Round-robin arbiter for one shared modulo counter. A grant is held until done,
// owner withdrawal or MAX_HOLD cycles, then one idle cycle is forced before the next grant.
module rr_counter_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input logic              clk,
    input logic              rst_n,
    rr_counter_arbiter_if.slave arb
);
    localparam int W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [W-1:0]  LAST_ID   = W'(N_REQ - 1);
    localparam logic [W:0]    NREQ_EXT  = (W + 1)'(N_REQ);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q;
    logic [W-1:0]     ptr_q;
    logic [HW-1:0]    hold_cnt_q;
    logic [N_REQ-1:0] gnt_q;
    logic [W-1:0]     gnt_id_q;
    logic             timeout_q;

    logic             found;
    logic [W-1:0]     winner;
    logic [W:0]       idx_ext;
    logic [N_REQ-1:0] win_oh;
    logic [W-1:0]     ptr_d;
    logic             rel_done, rel_wd, rel_to, release_now;

    // Scan ptr, ptr+1 .. wrapping; the first requester found wins.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx_ext = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_ext = {1'b0, ptr_q} + (W + 1)'(k);
            if (idx_ext >= NREQ_EXT) idx_ext = idx_ext - NREQ_EXT;
            if (!found && arb.req[idx_ext[W-1:0]]) begin
                found  = 1'b1;
                winner = idx_ext[W-1:0];
            end
        end
    end

    assign win_oh = N_REQ'(1) << winner;
    assign ptr_d  = (winner == LAST_ID) ? '0 : winner + W'(1);

    assign rel_done    = arb.done;
    assign rel_wd      = !arb.req[gnt_id_q];
    assign rel_to      = (hold_cnt_q == HOLD_LAST);
    assign release_now = rel_done | rel_wd | rel_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q    <= BUSY;
                        gnt_q      <= win_oh;
                        gnt_id_q   <= winner;
                        hold_cnt_q <= '0;
                        ptr_q      <= ptr_d;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state_q    <= IDLE;
                        gnt_q      <= '0;
                        gnt_id_q   <= '0;
                        hold_cnt_q <= '0;
                        // Only a pure hold-limit release is reported as a timeout.
                        timeout_q  <= rel_to & !rel_done & !rel_wd;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_valid = |gnt_q;
    assign arb.gnt_id    = gnt_id_q;
    assign arb.timeout   = timeout_q;
endmodule

// File: tb/tb_rr_counter_arbiter.sv
// Directed bench for rr_counter_arbiter (N_REQ=4, MAX_HOLD=8) plus a random soak
// checking one-hot grants, grant length and bounded waiting.
module tb_rr_counter_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    rr_counter_arbiter_if #(.N_REQ(4)) bus ();

    rr_counter_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, bus.gnt, 0);
        chk({tag, "_vld"}, bus.gnt_valid, 0);
        chk({tag, "_id"},  bus.gnt_id, 0);
    endtask

    task automatic chk_grant(input string tag, input int id);
        chk({tag, "_gnt"}, bus.gnt, 32'(4'b0001 << id));
        chk({tag, "_vld"}, bus.gnt_valid, 1);
        chk({tag, "_id"},  bus.gnt_id, id);
    endtask

    int          exp_seq [5] = '{0, 1, 2, 3, 0};
    int          wait_cnt [4];
    int          run_len;
    logic [3:0]  prev_gnt, req_seen;

    initial begin
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        #12;
        chk_idle("rst");
        chk("rst_to", bus.timeout, 0);
        chk("rst_ptr", dut.ptr_q, 0);
        rst_n = 1'b1;

        // T1: single requester
        tick();
        chk_idle("t1_noreq");
        bus.req = 4'b0100;
        tick();
        chk_grant("t1", 2);
        chk("t1_ptr", dut.ptr_q, 3);
        bus.req = 4'b0000;
        tick();
        chk_idle("t1_rel");
        chk("t1_to", bus.timeout, 0);

        // T2: all requesting, done on second grant cycle
        pulse_reset();
        bus.req = 4'b1111;
        tick();
        foreach (exp_seq[g]) begin
            chk_grant($sformatf("t2_g%0d", g), exp_seq[g]);
            tick();
            chk_grant($sformatf("t2_h%0d", g), exp_seq[g]);
            if (g == 3) chk("t2_ptrwrap", dut.ptr_q, 0);
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            chk_idle($sformatf("t2_idle%0d", g));
            chk("t2_to", bus.timeout, 0);
            tick();
        end
        bus.req = 4'b0000;
        tick();
        tick();

        // T3: hold limit forces release after 8 cycles
        pulse_reset();
        bus.req = 4'b0001;
        tick();
        chk_grant("t3_c0", 0);
        for (int c = 1; c < 8; c++) begin
            tick();
            chk_grant($sformatf("t3_c%0d", c), 0);
            chk("t3_noto", bus.timeout, 0);
        end
        tick();
        chk_idle("t3_rel");
        chk("t3_to", bus.timeout, 1);
        tick();
        chk_grant("t3_regnt", 0);
        chk("t3_to_clr", bus.timeout, 0);

        // T4a: done coincides with the last hold cycle
        for (int c = 1; c < 8; c++) tick();
        chk_grant("t4_h7", 0);
        chk("t4_hold7", dut.hold_cnt_q, 7);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_idle("t4_rel");
        chk("t4_to", bus.timeout, 0);
        // T4b: owner withdraws on its third grant cycle
        tick();
        chk_grant("t4_regnt", 0);
        tick();
        tick();
        chk_grant("t4_c3", 0);
        bus.req = 4'b0000;
        tick();
        chk_idle("t4_wd");
        chk("t4_wd_to", bus.timeout, 0);

        // T5: asynchronous reset in the middle of a grant
        pulse_reset();
        bus.req = 4'b0010;
        tick();
        chk_grant("t5_g", 1);
        for (int c = 0; c < 4; c++) tick();
        chk("t5_hold4", dut.hold_cnt_q, 4);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("t5_arst");
        chk("t5_ptr", dut.ptr_q, 0);
        chk("t5_to", bus.timeout, 0);
        bus.req = 4'b1010;
        rst_n = 1'b1;
        tick();
        chk_grant("t5_after", 1);

        // T6: random soak
        bus.req = 4'b0000;
        tick();
        tick();
        prev_gnt = 4'b0000;
        run_len  = 0;
        foreach (wait_cnt[i]) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) bus.req[b] = ~bus.req[b];
            bus.done = ($urandom_range(0, 5) == 0);
            req_seen = bus.req;
            tick();
            chk("t6_onehot0", $onehot0(bus.gnt), 1);
            chk("t6_vld", bus.gnt_valid, (bus.gnt != 0));
            chk("t6_id", (bus.gnt == 0) ? (bus.gnt_id == 0) : (bus.gnt == (4'b0001 << bus.gnt_id)), 1);
            run_len = (bus.gnt != 0) ? run_len + 1 : 0;
            chk("t6_len", (run_len <= 8), 1);
            for (int i = 0; i < 4; i++) begin
                if (!req_seen[i] || bus.gnt[i]) wait_cnt[i] = 0;
                else if (prev_gnt == 0 && bus.gnt != 0) begin
                    wait_cnt[i]++;
                    chk($sformatf("t6_starve%0d", i), (wait_cnt[i] <= 3), 1);
                end
            end
            prev_gnt = bus.gnt;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
